mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares the single-port record memory among up to N_REQ requesters: the byte-collecting loader (writes), the sparse multiply engine (reads) and the result transmitter (reads). It grants one memory access per cycle and supports locked bursts, so a requester can stream consecutive records without interleaving. Read data is returned with a per-requester valid strobe aligned to the memory's fixed read latency. It sits between the control/loader units and the memory macro.

## Interface
- N_REQ, 3, number of requesters; index 0 has highest priority out of reset
- ADDR_W, 16, memory address width
- DATA_W, 8, memory data width
- MEM_LAT, 1, memory read latency in cycles (≥1)
- MAX_BURST, 16, maximum consecutive locked accesses before forced rotation (≥1)

- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-high
- req  input  N_REQ  per-requester access request; hold until the access completes
- lock  input  N_REQ  keep grant for the following access (burst)
- we  input  N_REQ  1 = write, 0 = read
- addr  input  N_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- wdata  input  N_REQ*DATA_W  flattened write data, same packing
- gnt  output  N_REQ  registered one-hot (or zero) grant
- rvalid  output  N_REQ  read data valid for requester i
- rdata  output  DATA_W  read data, shared; qualify with rvalid
- mem_en  output  1  memory access enable
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after access

## Operation
- Access: occurs in any cycle where gnt[i] && req[i]; mem_en = |(gnt & req); mem_we/mem_addr/mem_wdata muxed combinationally from the owner's we/addr/wdata. With no access, mem_en = 0, mem_we = 0; address/data don't-care.
- Owner = index of the set gnt bit. Last-served pointer last is updated to the owner on every access.
- Next-grant rule, evaluated every cycle:
  - Keep: owner accessed this cycle, lock[owner] = 1, and burst_cnt < MAX_BURST-1 → gnt unchanged, burst_cnt + 1.
  - Otherwise: the first index with req set, searching last+1, last+2, … wrapping, last itself checked last → one-hot gnt, burst_cnt = 0. No req set → gnt = 0.
- A sole requester is re-granted every cycle (no bubbles).
- Owner drops req while granted: no access that cycle, lock ignored, normal rotation next cycle.
- Requester protocol: present we/addr/wdata with req; an access completes at the clock edge where gnt[i] && req[i]; the next beat's address may change after that edge.
- Read return: each read access pushes (valid, owner id) into a MAX_BURST-independent MEM_LAT-deep shift pipe; at its output, rvalid[id] = 1 for one cycle and rdata = mem_rdata. Writes push valid = 0.
- burst_cnt is sized by clog2(MAX_BURST); no overflow, since it never exceeds MAX_BURST-1.

## Timing
- Reset values: gnt = 0, rvalid = 0, mem_en = 0, mem_we = 0, burst_cnt = 0, last = N_REQ-1 (requester 0 wins first), read pipe cleared.
- Arbitration latency: req rising in cycle t → earliest gnt in t+1 → access completes at the end of t+1.
- Throughput: one access per cycle when any requester is pending.
- Read latency: rvalid[i] is high exactly MEM_LAT cycles after the access cycle.
- Fairness: an unlocked pending requester waits at most (N_REQ-1)*MAX_BURST access cycles.
- Reset mid-burst or with reads in flight: grant and pipe are cleared at the reset edge; rvalid is 0 the next cycle; in-flight reads are lost.
- Simultaneous requests: resolved only by the rotation order from last; the requester served most recently has the lowest priority.

## Test plan
- Reset: hold reset 3 cycles with all req = 1 → gnt = 0, rvalid = 0, mem_en = 0 throughout; after release, gnt = 3'b001 next cycle.
- Single read: req[1] = 1, we = 0, addr 0x0010, memory holds 0xA5 → gnt = 3'b010 one cycle later, mem_addr = 0x0010, mem_en = 1; next cycle rvalid = 3'b010, rdata = 0xA5.
- Contention: all req = 1, lock = 0 from reset → gnt sequence 001, 010, 100, 001, 010, 100 on consecutive cycles, mem_en continuously 1.
- Burst with MAX_BURST = 4: req[0] and lock[0] = 1, writes to 0x0100–0x0103, req[2] pending → four consecutive gnt = 001 accesses, then gnt = 100, then 001 again.
- Drop: owner 1 deasserts req while gnt = 010 → mem_en = 0 that cycle; next cycle gnt goes to the next pending requester, or 0 if none.
- Reset in flight: read accepted in cycle t, reset asserted in t → rvalid stays 0 in t+1 and gnt = 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Brief    : Requester-side and memory-side buses of the record memory
//             arbiter. The slave modport is the arbiter's view. The master
//             modport is the view of the requesters plus the memory macro.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    // requester side
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    // memory side
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    modport slave (
        input  req, lock, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, lock, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Round-robin arbiter for the single-port record memory. It grants
//             one access per cycle and supports locked bursts that are capped
//             at MAX_BURST beats. Read data returns with a per-requester valid
//             strobe MEM_LAT cycles after the access.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int c_id_w      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_cnt_w     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int c_burst_lim = MAX_BURST - 1;

    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   w_next_gnt;
    logic [c_id_w-1:0]  r_last;
    logic [c_id_w-1:0]  w_owner;
    logic [c_id_w-1:0]  w_last_eff;
    logic [c_cnt_w-1:0] r_burst_cnt;
    logic               w_access;
    logic               w_keep;
    logic               w_found;
    int                 w_idx;
    logic               w_owner_we;
    logic [ADDR_W-1:0]  w_owner_addr;
    logic [DATA_W-1:0]  w_owner_wdata;
    logic [MEM_LAT-1:0] r_pipe_vld;
    logic [c_id_w-1:0]  r_pipe_id [MEM_LAT];
    logic [N_REQ-1:0]   w_rvalid;

    // Decode the owner from the one-hot grant and mux its access fields
    always_comb begin
        w_owner       = '0;
        w_owner_we    = 1'b0;
        w_owner_addr  = '0;
        w_owner_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                w_owner       = c_id_w'(i);
                w_owner_we    = bus.we[i];
                w_owner_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                w_owner_wdata = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_access   = |(r_gnt & bus.req);
    assign w_keep     = w_access && bus.lock[w_owner] &&
                        (int'(r_burst_cnt) < c_burst_lim);
    // An access in this cycle makes its owner the most recently served
    // requester, so it drops to lowest priority in the search below.
    assign w_last_eff = w_access ? w_owner : r_last;

    // Rotating search from last+1, which wraps so that last is tried last
    always_comb begin
        w_next_gnt = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(w_last_eff) + k) % N_REQ;
            if (!w_found && bus.req[w_idx]) begin
                w_next_gnt[w_idx] = 1'b1;
                w_found           = 1'b1;
            end
        end
    end

    // Grant, burst counter and last-served pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt       <= '0;
            r_burst_cnt <= '0;
            r_last      <= c_id_w'(N_REQ - 1);
        end else begin
            if (w_access) begin
                r_last <= w_owner;
            end
            if (w_keep) begin
                r_burst_cnt <= r_burst_cnt + c_cnt_w'(1);
            end else begin
                r_gnt       <= w_next_gnt;
                r_burst_cnt <= '0;
            end
        end
    end

    // Read-return pipe that tracks which requester owns each in-flight read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                r_pipe_id[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_access && !w_owner_we;
            r_pipe_id[0]  <= w_owner;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

    // Steer the read strobe to the requester at the pipe output
    always_comb begin
        w_rvalid = '0;
        if (r_pipe_vld[MEM_LAT-1]) begin
            w_rvalid[r_pipe_id[MEM_LAT-1]] = 1'b1;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rvalid    = w_rvalid;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_en    = w_access;
    assign bus.mem_we    = w_access & w_owner_we;
    assign bus.mem_addr  = w_owner_addr;
    assign bus.mem_wdata = w_owner_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Directed self-checking bench for mem_arbiter (N_REQ=3,
//             MAX_BURST=4, MEM_LAT=1) with a one-cycle-latency memory model
//             and a read-return scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int N_REQ     = 3;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int MEM_LAT   = 1;
    localparam int MAX_BURST = 4;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } sb_t;

    logic clk;
    logic reset;
    int   cyc       = 0;
    int   n_vec     = 0;
    int   n_err     = 0;
    sb_t  sb_q[$];

    logic [7:0] mem [0:65535];
    logic [7:0] mem_rdata_r;

    mem_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MEM_LAT(MEM_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory with one cycle of read latency, preloaded during reset
    assign bus.mem_rdata = mem_rdata_r;
    always @(posedge clk) begin
        if (reset) begin
            mem[16'h0010] <= 8'hA5;
            mem[16'h0020] <= 8'h5A;
            mem[16'h0021] <= 8'h3C;
            mem[16'h0022] <= 8'hC3;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            mem_rdata_r <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int due, input int id, input logic [7:0] d);
        sb_t e;
        e.due  = due;
        e.id   = id;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Read-return checker: rvalid must be zero unless a read is due this cycle
    logic [2:0] exp_rv;
    sb_t        sb_e;
    logic       sb_hit;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            exp_rv = 3'b000;
            sb_hit = 1'b0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                sb_e   = sb_q.pop_front();
                exp_rv = 3'(3'b001 << sb_e.id);
                sb_hit = 1'b1;
            end
            chk("rvalid", 32'(bus.rvalid), 32'(exp_rv));
            if (sb_hit) chk("rdata", 32'(bus.rdata), 32'(sb_e.data));
        end
    end

    logic [2:0] cont_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [7:0] cont_dat [3] = '{8'h5A, 8'h3C, 8'hC3};

    initial begin
        reset     = 1'b1;
        bus.req   = 3'b111;
        bus.lock  = 3'b000;
        bus.we    = 3'b000;
        bus.addr  = {16'h0022, 16'h0021, 16'h0020};
        bus.wdata = '0;

        // reset held three cycles with every requester asking
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            mid();
            chk("reset_gnt", 32'(bus.gnt), 32'd0);
            chk("reset_mem_en", 32'(bus.mem_en), 32'd0);
        end
        reset = 1'b0;

        // contention from reset: strict rotation, one access per cycle
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            mid();
            chk("cont_gnt", 32'(bus.gnt), 32'(cont_gnt[k]));
            chk("cont_mem_en", 32'(bus.mem_en), 32'd1);
            chk("cont_mem_we", 32'(bus.mem_we), 32'd0);
            chk("cont_addr", 32'(bus.mem_addr), 32'h0020 + 32'(k % 3));
            sb_push(cyc + 1, k % 3, cont_dat[k % 3]);
        end

        // owner 0 drops with nobody else pending
        step(); bus.req = 3'b000;
        mid();  chk("drop0_gnt", 32'(bus.gnt), 32'b001);
                chk("drop0_mem_en", 32'(bus.mem_en), 32'd0);

        // single read by requester 1
        step(); bus.req = 3'b010; bus.addr[16 +: 16] = 16'h0010;
        mid();  chk("idle_gnt", 32'(bus.gnt), 32'd0);
                chk("idle_mem_en", 32'(bus.mem_en), 32'd0);
        step();
        mid();  chk("rd1_gnt", 32'(bus.gnt), 32'b010);
                chk("rd1_mem_en", 32'(bus.mem_en), 32'd1);
                chk("rd1_addr", 32'(bus.mem_addr), 32'h0010);
                sb_push(cyc + 1, 1, 8'hA5);
        step(); bus.req = 3'b000;
        mid();  chk("sole_regrant_gnt", 32'(bus.gnt), 32'b010);
                chk("sole_regrant_en", 32'(bus.mem_en), 32'd0);

        // owner 1 drops while 0 and 2 are pending
        step(); bus.req = 3'b010;
        mid();  chk("gap_gnt", 32'(bus.gnt), 32'd0);
        step();
        mid();  chk("rd2_gnt", 32'(bus.gnt), 32'b010);
                sb_push(cyc + 1, 1, 8'hA5);
        step(); bus.req = 3'b101; bus.we = 3'b101;
                bus.addr  = {16'h0301, 16'h0010, 16'h0300};
                bus.wdata = {8'h22, 8'h00, 8'h11};
        mid();  chk("drop1_gnt", 32'(bus.gnt), 32'b010);
                chk("drop1_mem_en", 32'(bus.mem_en), 32'd0);
        step();
        mid();  chk("after_drop_gnt", 32'(bus.gnt), 32'b100);
                chk("after_drop_we", 32'(bus.mem_we), 32'd1);
                chk("after_drop_addr", 32'(bus.mem_addr), 32'h0301);
                chk("after_drop_wdata", 32'(bus.mem_wdata), 32'h22);

        // read accepted in the same cycle that reset is asserted
        step(); bus.req = 3'b001; bus.we = 3'b000; bus.addr[0 +: 16] = 16'h0010;
                reset = 1'b1;
        mid();  chk("rst_rd_gnt", 32'(bus.gnt), 32'b001);
                chk("rst_rd_en", 32'(bus.mem_en), 32'd1);
        step(); reset = 1'b0; bus.req = 3'b000;
        mid();  chk("rst_fl_gnt", 32'(bus.gnt), 32'd0);
                chk("rst_fl_rvalid", 32'(bus.rvalid), 32'd0);

        // locked burst of four writes by 0 with 2 pending
        step(); bus.req = 3'b101; bus.lock = 3'b001; bus.we = 3'b101;
                bus.addr  = {16'h0200, 16'h0000, 16'h0100};
                bus.wdata = {8'h77, 8'h00, 8'hB0};
        for (int k = 0; k < 4; k++) begin
            step();
            if (k > 0) begin
                bus.addr[0 +: 16]  = 16'h0100 + 16'(k);
                bus.wdata[0 +: 8]  = 8'hB0 + 8'(k);
            end
            mid();
            chk("burst_gnt", 32'(bus.gnt), 32'b001);
            chk("burst_addr", 32'(bus.mem_addr), 32'h0100 + 32'(k));
            chk("burst_wdata", 32'(bus.mem_wdata), 32'hB0 + 32'(k));
            chk("burst_we", 32'(bus.mem_we), 32'd1);
        end
        step(); bus.addr[0 +: 16] = 16'h0104; bus.wdata[0 +: 8] = 8'hB4;
        mid();  chk("burst_rot_gnt", 32'(bus.gnt), 32'b100);
                chk("burst_rot_addr", 32'(bus.mem_addr), 32'h0200);
        step(); bus.req = 3'b001;
        mid();  chk("burst_back_gnt", 32'(bus.gnt), 32'b001);
                chk("burst_back_addr", 32'(bus.mem_addr), 32'h0104);

        // locked owner drops; then read back a burst beat
        step(); bus.req = 3'b010; bus.lock = 3'b000; bus.we = 3'b000;
                bus.addr[16 +: 16] = 16'h0102;
        mid();  chk("lock_drop_gnt", 32'(bus.gnt), 32'b001);
                chk("lock_drop_en", 32'(bus.mem_en), 32'd0);
        step();
        mid();  chk("rdback_gnt", 32'(bus.gnt), 32'b010);
                chk("rdback_addr", 32'(bus.mem_addr), 32'h0102);
                sb_push(cyc + 1, 1, 8'hB2);
        step(); bus.req = 3'b000;
        step();
        mid();  chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
